rr_stream_arbiter: RTL and testbench

- Round-robin arbiter that shares one ready/valid stream between NUM_REQ_P requesters.
- Typical use: several producers (weight loader, activation loader, host writes) feeding one shared fifo or systolic-array input.
- The winner's beat is captured in a single output register, tagged with the source index.
- Fair, starvation-free service under continuous contention.

---
 rtl/rr_stream_arbiter_pkg.sv | 14 +
 rtl/rr_stream_arbiter_priority_select.sv | 45 ++++
 rtl/rr_stream_arbiter.sv | 117 +++++++++++
 tb/tb_rr_stream_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/rr_stream_arbiter_pkg.sv
// Shared types and helpers for the round-robin stream arbiter.
package slugtpu_arb_pkg;

    // Index width for n requesters; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

    localparam int NUM_REQ_DEF = 32'sd4;
    localparam int SRC_W_DEF   = idx_width(NUM_REQ_DEF);

    typedef logic [SRC_W_DEF-1:0] src_idx_t;

endpackage

// File: rtl/rr_stream_arbiter_priority_select.sv
// Rotating priority encoder: first set request strictly after last_i, wrapping at NUM_REQ_P-1.
module rr_priority_select
    import slugtpu_arb_pkg::*;
#(
    parameter  int NUM_REQ_P = 4,
    localparam int IDX_W     = idx_width(NUM_REQ_P)
) (
    input  logic [NUM_REQ_P-1:0] req_i,
    input  logic [IDX_W-1:0]     last_i,
    output logic [NUM_REQ_P-1:0] grant_o,
    output logic [IDX_W-1:0]     grant_idx_o,
    output logic                 any_o
);

    logic             hit_s;
    logic [IDX_W-1:0] idx_s;

    // Scan from last_i+1 modulo NUM_REQ_P so unused indices are never produced.
    always_comb begin
        hit_s = 1'b0;
        idx_s = {IDX_W{1'b0}};
        for (int off = 1; off <= NUM_REQ_P; off++) begin
            int cand;
            cand = (int'(last_i) + off) % NUM_REQ_P;
            if (!hit_s && req_i[cand]) begin
                hit_s = 1'b1;
                idx_s = IDX_W'(cand);
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Drive the one-hot, index and any-valid views of the winner.
    always_comb begin
        any_o       = hit_s;
        grant_idx_o = idx_s;
        if (hit_s) begin
            grant_o = {{(NUM_REQ_P-1){1'b0}}, 1'b1} << idx_s;
        end else begin
            grant_o = {NUM_REQ_P{1'b0}};
        end
    end

endmodule

// File: rtl/rr_stream_arbiter.sv
// Round-robin arbiter sharing one ready/valid stream with a registered, source-tagged output.
// Optional burst lock enabled by defining RR_STREAM_ARBITER_BURST_EN.
module rr_stream_arbiter
    import slugtpu_arb_pkg::*;
#(
    parameter  int NUM_REQ_P = 4,
    parameter  int WIDTH_P   = 8,
    parameter  int BURST_P   = 4,
    localparam int IDX_W     = idx_width(NUM_REQ_P)
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_REQ_P-1:0]         valid_i,
    input  logic [NUM_REQ_P*WIDTH_P-1:0] data_i,
    output logic [NUM_REQ_P-1:0]         ready_o,
    output logic                         valid_o,
    input  logic                         ready_i,
    output logic [WIDTH_P-1:0]           data_o,
    output logic [IDX_W-1:0]             src_o
);

    localparam int CNT_W = $clog2(BURST_P + 1);

    logic                 valid_q, valid_d;
    logic [WIDTH_P-1:0]   data_q, data_d;
    logic [IDX_W-1:0]     src_q, src_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic [CNT_W-1:0]     burst_cnt_q, burst_cnt_d;

    logic                 load_s;
    logic                 lock_s;
    logic                 xfer_s;
    logic [NUM_REQ_P-1:0] sel_grant_s;
    logic [IDX_W-1:0]     sel_idx_s;
    logic                 sel_any_s;
    logic [NUM_REQ_P-1:0] win_onehot_s;
    logic [IDX_W-1:0]     win_idx_s;

    rr_priority_select #(
        .NUM_REQ_P (NUM_REQ_P)
    ) u_select (
        .req_i       (valid_i),
        .last_i      (last_q),
        .grant_o     (sel_grant_s),
        .grant_idx_o (sel_idx_s),
        .any_o       (sel_any_s)
    );

    // Winner choice: a live burst lock overrides the rotation (counter stays zero without the burst feature).
    always_comb begin
        load_s = !valid_q || ready_i;
        lock_s = (burst_cnt_q != {CNT_W{1'b0}}) && (burst_cnt_q < CNT_W'(BURST_P)) && valid_i[last_q];
        if (lock_s) begin
            win_onehot_s = {{(NUM_REQ_P-1){1'b0}}, 1'b1} << last_q;
            win_idx_s    = last_q;
        end else begin
            win_onehot_s = sel_grant_s;
            win_idx_s    = sel_idx_s;
        end
        xfer_s = load_s && (lock_s || sel_any_s);
        if (xfer_s) begin
            ready_o = win_onehot_s;
        end else begin
            ready_o = {NUM_REQ_P{1'b0}};
        end
    end

    // Next state of the output register, pointer and burst counter.
    always_comb begin
        valid_d     = valid_q;
        data_d      = data_q;
        src_d       = src_q;
        last_d      = last_q;
        burst_cnt_d = {CNT_W{1'b0}};
        if (xfer_s) begin
            valid_d = 1'b1;
            data_d  = data_i[int'(win_idx_s)*WIDTH_P +: WIDTH_P];
            src_d   = win_idx_s;
            last_d  = win_idx_s;
        end else if (ready_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
`ifdef RR_STREAM_ARBITER_BURST_EN
        if (xfer_s) begin
            burst_cnt_d = lock_s ? (burst_cnt_q + CNT_W'(1'b1)) : CNT_W'(1'b1);
        end else if (lock_s) begin
            burst_cnt_d = burst_cnt_q;
        end else begin
            burst_cnt_d = {CNT_W{1'b0}};
        end
`endif
    end

    // State registers with synchronous reset; pointer resets so requester 0 wins first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= 1'b0;
            data_q      <= {WIDTH_P{1'b0}};
            src_q       <= {IDX_W{1'b0}};
            last_q      <= IDX_W'(NUM_REQ_P - 1);
            burst_cnt_q <= {CNT_W{1'b0}};
        end else begin
            valid_q     <= valid_d;
            data_q      <= data_d;
            src_q       <= src_d;
            last_q      <= last_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign src_o   = src_q;

endmodule

// File: tb/tb_rr_stream_arbiter.sv
// Randomized and directed bench for rr_stream_arbiter against a queue-free behavioural model.
module tb_rr_stream_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int BURST = 4;

    logic           clk = 1'b0;
    logic           rst_i;
    logic [N-1:0]   valid_i;
    logic [N*W-1:0] data_i;
    logic [N-1:0]   ready_o;
    logic           valid_o;
    logic           ready_i;
    logic [W-1:0]   data_o;
    logic [1:0]     src_o;

    int total = 0;
    int bad   = 0;

    // Behavioural model state: output register contents, rotation pointer, beats in current burst.
    bit       m_valid;
    logic [7:0] m_data;
    int       m_src;
    int       m_ptr;
    int       m_cnt;

    always #5 clk = ~clk;

    rr_stream_arbiter #(
        .NUM_REQ_P (N),
        .WIDTH_P   (W),
        .BURST_P   (BURST)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o),
        .src_o   (src_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = 8'h00;
        m_src   = 0;
        m_ptr   = N - 1;
        m_cnt   = 0;
    endtask

    // One clock cycle, entered and left on the falling edge.
    task automatic cycle(input logic rst, input logic [N-1:0] v, input logic [N*W-1:0] d, input logic r);
        int         win;
        bit         load;
        bit         locked;
        logic [N-1:0] er;
        rst_i   = rst;
        valid_i = v;
        data_i  = d;
        ready_i = r;
        #1;
        load   = !m_valid || r;
        locked = 1'b0;
        win    = -1;
`ifdef RR_STREAM_ARBITER_BURST_EN
        locked = (m_cnt > 0) && (m_cnt < BURST) && v[m_ptr];
`endif
        if (locked) win = m_ptr;
        for (int off = 1; off <= N; off++) begin
            if (win < 0 && v[(m_ptr + off) % N]) win = (m_ptr + off) % N;
        end
        er = (load && win >= 0) ? N'(1 << win) : '0;
        check_eq("ready_o", 32'(ready_o), 32'(er));
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (load && win >= 0) begin
            m_cnt   = locked ? m_cnt + 1 : 1;
            m_valid = 1'b1;
            m_data  = d[win*W +: W];
            m_src   = win;
            m_ptr   = win;
        end else begin
            if (!locked) m_cnt = 0;
            if (r) m_valid = 1'b0;
        end
        @(negedge clk);
        check_eq("valid_o", 32'(valid_o), 32'(m_valid));
        check_eq("data_o", 32'(data_o), 32'(m_data));
        check_eq("src_o", 32'(src_o), 32'(m_src));
    endtask

    function automatic logic [N*W-1:0] rnd_data();
        return {$urandom, $urandom} [N*W-1:0];
    endfunction

    initial begin
        int seq_def [8];
        int skip_def[6];
        int burst_s [9];
        seq_def  = '{0, 1, 2, 3, 0, 1, 2, 3};
        skip_def = '{0, 1, 3, 0, 1, 3};
        burst_s  = '{0, 0, 0, 0, 1, 1, 1, 1, 0};

        rst_i   = 1'b1;
        valid_i = '0;
        data_i  = '0;
        ready_i = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_valid", 32'(valid_o), 32'd0);
        check_eq("rst_data", 32'(data_o), 32'd0);
        check_eq("rst_src", 32'(src_o), 32'd0);
        check_eq("rst_ready", 32'(ready_o), 32'd0);

        // Single requester.
        cycle(1'b0, 4'b0100, 32'h005A_0000, 1'b1);
        check_eq("single_valid", 32'(valid_o), 32'd1);
        check_eq("single_data", 32'(data_o), 32'h5A);
        check_eq("single_src", 32'(src_o), 32'd2);

        // Full contention from reset.
        cycle(1'b1, 4'b0000, '0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 4'b1111, rnd_data(), 1'b1);
            check_eq("contend_valid", 32'(valid_o), 32'd1);
`ifdef RR_STREAM_ARBITER_BURST_EN
            check_eq("contend_src", 32'(src_o), 32'(i / BURST));
`else
            check_eq("contend_src", 32'(src_o), 32'(seq_def[i]));
`endif
        end

        // Backpressure holds the register and blocks grants.
        cycle(1'b1, 4'b0000, '0, 1'b1);
        cycle(1'b0, 4'b1111, 32'h4433_2211, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 4'b1111, rnd_data(), 1'b0);
            check_eq("bp_ready", 32'(ready_o), 32'd0);
            check_eq("bp_data", 32'(data_o), 32'h11);
            check_eq("bp_src", 32'(src_o), 32'd0);
        end
        cycle(1'b0, 4'b1111, rnd_data(), 1'b1);
`ifdef RR_STREAM_ARBITER_BURST_EN
        check_eq("bp_release_src", 32'(src_o), 32'd0);
`else
        check_eq("bp_release_src", 32'(src_o), 32'd1);
`endif

        // Idle requester skipped.
        cycle(1'b1, 4'b0000, '0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 4'b1011, rnd_data(), 1'b1);
`ifndef RR_STREAM_ARBITER_BURST_EN
            check_eq("skip_src", 32'(src_o), 32'(skip_def[i]));
`endif
        end

`ifdef RR_STREAM_ARBITER_BURST_EN
        cycle(1'b1, 4'b0000, '0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 4'b0011, rnd_data(), 1'b1);
            check_eq("burst_src", 32'(src_o), 32'(burst_s[i]));
        end
`endif

        // Reset mid-stream.
        cycle(1'b0, 4'b1111, rnd_data(), 1'b1);
        cycle(1'b0, 4'b0110, rnd_data(), 1'b0);
        cycle(1'b1, 4'b1111, rnd_data(), 1'b0);
        check_eq("midrst_valid", 32'(valid_o), 32'd0);
        cycle(1'b0, 4'b1111, rnd_data(), 1'b1);
        check_eq("midrst_first_src", 32'(src_o), 32'd0);

        // Random traffic with occasional backpressure and rare resets.
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom_range(99) == 0) ? 1'b1 : 1'b0,
                  N'($urandom_range(15)),
                  rnd_data(),
                  ($urandom_range(9) < 7) ? 1'b1 : 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
